// File: rtl/fetch_stage_pkg.sv
// Shared RV32I fetch constants: reset PC, imem width, NOP, FSM states
// and the IF/ID bundle type.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          IMEM_AW_DEF  = 10;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  localparam if_id_t IF_ID_RESET = '{
    valid: 1'b0,
    pc:    32'h0,
    instr: NOP
  };

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP bubble, hold freezes.
// Ports: clk, rst, hold, flush, d (next bundle), q (registered bundle).
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // Flush keeps the old pc; only valid and instr matter downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= IF_ID_RESET;
    end else if (flush) begin
      q.valid <= 1'b0;
      q.instr <= NOP;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC register, IDLE/RUN/HOLD FSM, fetch counter.
// Ports: clk, rst, stall, redirect_*, imem_* handshake, if_id_* out.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IMEM_AW  = IMEM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_req,
  input  logic [31:0]        imem_instr,
  input  logic               imem_valid,
  output logic               if_id_valid,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        fetch_count
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  cnt;
  logic         req;
  logic         busy;
  logic         flush;
  logic         hold;
  if_id_t       d;
  if_id_t       q;

  assign busy = (state != S_IDLE);

  // Redirect beats stall; a missing instruction becomes a bubble.
  assign flush = busy
               & (redirect_valid | (!stall & !imem_valid));
  assign hold  = !busy | stall;

  assign d = '{valid: 1'b1, pc: pc, instr: imem_instr};

  // HOLD with stall low advances like RUN on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      cnt   <= 32'h0;
      req   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state <= S_RUN;
          req   <= 1'b1;
        end
        default: begin
          if (redirect_valid) begin
            state <= S_RUN;
            pc    <= redirect_pc & ~32'h3;
          end else if (stall) begin
            state <= S_HOLD;
          end else begin
            state <= S_RUN;
            if (imem_valid) begin
              pc  <= pc + 32'd4;
              cnt <= cnt + 32'd1;
            end
          end
        end
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk   (clk),
    .rst   (rst),
    .hold  (hold),
    .flush (flush),
    .d     (d),
    .q     (q)
  );

  assign imem_addr   = pc[IMEM_AW+1:2];
  assign imem_req    = req;
  assign if_id_valid = q.valid;
  assign if_id_pc    = q.pc;
  assign if_id_instr = q.instr;
  assign fetch_count = cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus
// randomized traffic against a behavioural fetch model.
module tb_fetch_stage;

  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [9:0]  imem_addr;
  logic        imem_req;
  logic [31:0] imem_instr;
  logic        imem_valid = 1'b1;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int failures = 0;

  // model state
  bit          m_idle;
  logic [31:0] m_pc;
  bit          m_v;
  logic [31:0] m_ipc;
  logic [31:0] m_ins;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_instr     (imem_instr),
    .imem_valid     (imem_valid),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .fetch_count    (fetch_count)
  );

  // Advance the model by the current inputs, then clock the DUT.
  task automatic step();
    logic [31:0] w;
    w = m_pc;
    if (rst) begin
      m_idle = 1; m_pc = 32'h0; m_v = 0;
      m_ipc = 32'h0; m_ins = NOPI; m_cnt = 32'h0;
    end else if (m_idle) begin
      m_idle = 0;
    end else if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_v = 0; m_ins = NOPI;
    end else if (stall) begin
    end else if (!imem_valid) begin
      m_v = 0; m_ins = NOPI;
    end else begin
      m_v = 1; m_ipc = w;
      m_ins = mem[w[11:2]];
      m_pc = w + 32'd4;
      m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    stall = 0; redirect_valid = 0;
    redirect_pc = 0; imem_valid = 1;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 10'h0 ||
        if_id_valid !== 1'b0 || if_id_pc !== 32'h0 ||
        if_id_instr !== NOPI || fetch_count !== 32'h0) begin
      failures++;
      $display("FAIL reset: req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d",
               imem_req, imem_addr, if_id_valid, if_id_pc,
               if_id_instr, fetch_count);
    end
    redirect_valid = 1; redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h0 ||
        if_id_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_exit: req=%b addr=%h v=%b want 1 000 0",
               imem_req, imem_addr, if_id_valid);
    end
  endtask

  task automatic test_free_run();
    logic [9:0] ea [4] = '{10'd0, 10'd1, 10'd2, 10'd3};
    do_reset(); step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_addr !== ea[i]) begin
        failures++;
        $display("FAIL run_addr%0d: got %h want %h",
                 i, imem_addr, ea[i]);
      end
      if (i > 0) begin
        checks++;
        if (if_id_valid !== 1'b1 ||
            if_id_pc !== 32'(4 * (i - 1)) ||
            if_id_instr !== mem[i-1]) begin
          failures++;
          $display("FAIL run_ifid%0d: v=%b pc=%h want pc=%h",
                   i, if_id_valid, if_id_pc, 4 * (i - 1));
        end
      end
      if (i < 3) step();
    end
    checks++;
    if (fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL run_count: got %0d want 3", fetch_count);
    end
  endtask

  task automatic test_stall();
    do_reset(); step(); step(); step();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (imem_addr !== 10'd2 || if_id_pc !== 32'd4 ||
          if_id_instr !== mem[1] || fetch_count !== 32'd2) begin
        failures++;
        $display("FAIL stall%0d: addr=%h pc=%h cnt=%0d want 2 4 2",
                 i, imem_addr, if_id_pc, fetch_count);
      end
    end
    stall = 0;
    step();
    checks++;
    if (if_id_pc !== 32'd8 || if_id_valid !== 1'b1 ||
        if_id_instr !== mem[2] || imem_addr !== 10'd3) begin
      failures++;
      $display("FAIL stall_resume: pc=%h v=%b addr=%h want 8 1 3",
               if_id_pc, if_id_valid, imem_addr);
    end
  endtask

  task automatic test_redirect_stall();
    stall = 1; redirect_valid = 1;
    redirect_pc = 32'h0000_0103;
    step();
    idle_in();
    checks++;
    if (imem_addr !== 10'h040 || if_id_valid !== 1'b0 ||
        if_id_instr !== NOPI) begin
      failures++;
      $display("FAIL redir_stall: addr=%h v=%b ins=%h want 040 0 13",
               imem_addr, if_id_valid, if_id_instr);
    end
    step();
    checks++;
    if (if_id_pc !== 32'h100 || if_id_valid !== 1'b1 ||
        if_id_instr !== mem[10'h40]) begin
      failures++;
      $display("FAIL redir_target: pc=%h v=%b want 100 1",
               if_id_pc, if_id_valid);
    end
  endtask

  task automatic test_bubble();
    logic [31:0] c0;
    redirect_valid = 1; redirect_pc = 32'h10;
    step();
    idle_in();
    c0 = fetch_count;
    imem_valid = 0;
    step();
    imem_valid = 1;
    checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== NOPI ||
        imem_addr !== 10'd4 || fetch_count !== c0) begin
      failures++;
      $display("FAIL bubble: v=%b ins=%h addr=%h cnt=%0d want 0 13 4 %0d",
               if_id_valid, if_id_instr, imem_addr, fetch_count, c0);
    end
    step();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h10 ||
        fetch_count !== c0 + 32'd1) begin
      failures++;
      $display("FAIL bubble_fill: v=%b pc=%h cnt=%0d want 1 10 %0d",
               if_id_valid, if_id_pc, fetch_count, c0 + 1);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1; redirect_pc = 32'h0000_0FFC;
    step();
    idle_in();
    checks++;
    if (imem_addr !== 10'h3FF) begin
      failures++;
      $display("FAIL wrap_pre: addr=%h want 3ff", imem_addr);
    end
    step();
    checks++;
    if (imem_addr !== 10'h000 || if_id_pc !== 32'hFFC ||
        if_id_instr !== mem[10'h3FF]) begin
      failures++;
      $display("FAIL wrap_post: addr=%h pc=%h want 000 ffc",
               imem_addr, if_id_pc);
    end
    step();
    checks++;
    if (if_id_pc !== 32'h1000 || imem_addr !== 10'h001) begin
      failures++;
      $display("FAIL wrap_next: pc=%h addr=%h want 1000 001",
               if_id_pc, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    redirect_valid = 1; redirect_pc = 32'h20;
    step();
    stall = 1; redirect_valid = 1;
    redirect_pc = 32'h400; rst = 1;
    step();
    rst = 0; idle_in();
    checks++;
    if (imem_addr !== 10'h0 || imem_req !== 1'b0 ||
        if_id_valid !== 1'b0 || fetch_count !== 32'h0 ||
        if_id_instr !== NOPI || if_id_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: addr=%h req=%b v=%b cnt=%0d",
               imem_addr, imem_req, if_id_valid, fetch_count);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h0) begin
      failures++;
      $display("FAIL reset_mid_run: req=%b addr=%h want 1 000",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 59) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      stall          = ($urandom_range(0, 4) == 0);
      imem_valid     = ($urandom_range(0, 4) != 0);
      redirect_pc    = $urandom;
      step();
      checks++;
      if (imem_req !== !m_idle || imem_addr !== m_pc[11:2] ||
          if_id_valid !== m_v || if_id_pc !== m_ipc ||
          if_id_instr !== m_ins || fetch_count !== m_cnt) begin
        failures++;
        if (bad < 10)
          $display("FAIL rand%0d: req=%b/%b addr=%h/%h v=%b/%b pc=%h/%h ins=%h/%h cnt=%0d/%0d",
                   i, imem_req, !m_idle, imem_addr, m_pc[11:2],
                   if_id_valid, m_v, if_id_pc, m_ipc,
                   if_id_instr, m_ins, fetch_count, m_cnt);
        bad++;
      end
    end
    idle_in(); rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    m_idle = 1; m_pc = 0; m_v = 0;
    m_ipc = 0; m_ins = NOPI; m_cnt = 0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_bubble();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter IMEM_AW, default 10: instruction-memory word-address width.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 stall  in  1  hazard-unit hold: freeze PC and IF/ID.
REQ-006 redirect_valid  in  1  taken branch/jump resolved downstream.
REQ-007 redirect_pc  in  32  target PC for the redirect.
REQ-008 imem_addr  out  IMEM_AW  word address to instr_mem, equal to pc[IMEM_AW+1:2].
REQ-009 imem_req  out  1  fetch request to instr_mem.
REQ-010 imem_instr  in  32  instruction word returned combinationally by instr_mem.
REQ-011 imem_valid  in  1  imem_instr is valid this cycle.
REQ-012 if_id_valid  out  1  IF/ID register holds a real instruction.
REQ-013 if_id_pc  out  32  PC of the instruction in IF/ID.
REQ-014 if_id_instr  out  32  instruction in IF/ID; NOP (32'h0000_0013) when invalid.
REQ-015 fetch_count  out  32  number of instructions delivered into IF/ID since reset.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN and HOLD.
REQ-017 IDLE SHALL last exactly one cycle after reset with imem_req=0, then go unconditionally to RUN.
REQ-018 In RUN and HOLD the block SHALL drive imem_req=1 and imem_addr from the current PC.
REQ-019 Per-edge priority SHALL be: rst > redirect_valid > stall > !imem_valid > advance.
REQ-020 Advance (RUN, no stall, imem_valid=1): pc <= pc+4; IF/ID <= {valid=1, pc, imem_instr}; fetch_count += 1. The instruction SHALL appear in IF/ID one cycle after its address is presented.
REQ-021 Redirect: pc <= {redirect_pc[31:2],2'b00}; if_id_valid <= 0; if_id_instr <= NOP; state <= RUN. Redirect SHALL override a simultaneous stall.
REQ-022 Stall (no redirect): pc, IF/ID and fetch_count SHALL hold; state <= HOLD. HOLD SHALL return to RUN on the first cycle with stall=0.
REQ-023 imem_valid=0 while requesting, with no stall and no redirect: pc holds; if_id_valid <= 0; if_id_instr <= NOP (bubble).
REQ-024 PC arithmetic SHALL be modulo 2^32; imem_addr SHALL wrap naturally at 2^IMEM_AW words (4 KiB at default).
REQ-025 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-026 redirect_valid SHALL be ignored while in IDLE.

Reset
REQ-027 On rst=1 at an edge: pc=RESET_PC, state=IDLE, if_id_valid=0, if_id_pc=0, if_id_instr=NOP, fetch_count=0.
REQ-028 While in IDLE, imem_req SHALL be 0 and imem_addr SHALL equal RESET_PC[IMEM_AW+1:2].
REQ-029 Reset asserted mid-operation (including during stall or redirect) SHALL discard all in-flight state within one edge.

Structure
REQ-030 RESET_PC default, IMEM_AW, the NOP encoding and the FSM state encodings SHALL live in the shared RV32I constants package or header.
REQ-031 The IF/ID pipeline register (valid/pc/instr, with hold and flush inputs) SHALL be a separate sub-module named if_id_reg.
REQ-032 The PC register, the FSM and fetch_count SHALL stay in fetch_stage.

Verification
REQ-033 Reset, then 4 cycles free-running with imem_valid=1 -> imem_addr 0,1,2,3 and if_id_pc 0,4,8 one cycle later, with if_id_valid=1 and fetch_count=3.
REQ-034 stall=1 for 2 cycles at pc=8 -> imem_addr holds at 2 and IF/ID holds pc=4 and its instruction; the flow resumes with pc=8 in IF/ID one cycle after stall drops.
REQ-035 redirect_valid=1 with redirect_pc=32'h0000_0103 while stall=1 -> next cycle pc=0x100, imem_addr=0x040, if_id_valid=0 and if_id_instr=NOP.
REQ-036 imem_valid=0 for 1 cycle at pc=0x10 -> a single bubble in IF/ID; then pc=0x10 is delivered and fetch_count increments exactly once.
REQ-037 Redirect to 32'h0000_0FFC, then advance -> imem_addr 0x3FF then 0x000 while pc=0x1000.
REQ-038 rst=1 asserted mid-run at pc=0x20 -> after the edge: pc=0, if_id_valid=0, fetch_count=0, imem_req=0 for one cycle.
